cone_bist_ctrl: RTL and testbench

- Sequential stimulus/response harness for the combinational partial-output cones extracted from the s13207 benchmark. Example: the 18-input, 1-output n594 cone.
- Drives the cone's primary inputs from an LFSR pattern generator.
- Samples the cone's single output each pattern and compacts it into a serial signature register.
- On completion, compares the signature against a supplied golden value. Sits between the fault-injection/reliability test controller and one cone instance.

---
 rtl/cone_bist_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cone_bist_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cone_bist_ctrl.sv
// cone_bist_ctrl
// Stimulus/response harness for one combinational output cone (for example
// the 18-input n594 cone of s13207). An 18-bit LFSR drives the cone inputs,
// the single cone output is folded into a 16-bit serial signature (CCITT
// polynomial 0x1021) and the final signature is compared with a golden value.
//
// Ports:
//   CK        clock, rising edge
//   RST       synchronous active-high reset
//   start     one-cycle request to begin a run (ignored while busy)
//   abort     cancel a run in progress (no done pulse, pass stays 0)
//   golden    expected signature, sampled in DONE
//   resp      cone output, combinational from pattern
//   pattern   registered cone input vector (low N_IN LFSR bits)
//   busy      high from LOAD through DONE
//   done      one-cycle pulse while in DONE
//   pass      signature == golden, valid from the cycle after done
//   signature current signature register
//   count     patterns completed in the current/last run
//
// N_IN must not exceed 18 (the LFSR width).
module cone_bist_ctrl #(
   parameter int          N_IN     = 18,
   parameter int          PATTERNS = 1024,
   parameter logic [17:0] SEED     = 18'h00001
) (
   input  logic            CK,
   input  logic            RST,
   input  logic            start,
   input  logic            abort,
   input  logic [15:0]     golden,
   input  logic            resp,
   output logic [N_IN-1:0] pattern,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [15:0]     signature,
   output logic [15:0]     count
);

   // A zero seed would lock the LFSR in its all-zero state.
   localparam logic [17:0] LOAD_VAL = (SEED == 18'h00000) ? 18'h00001 : SEED;
   localparam logic [15:0] PAT_LAST = 16'(PATTERNS);
   localparam logic [15:0] SIG_POLY = 16'h1021;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CAPTURE = 3'd2,
      S_STEP    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // Serial signature step: shift left, fold in polynomial when the
   // outgoing bit differs from the incoming response bit.
   function automatic logic [15:0] sig_next(input logic [15:0] sig, input logic bit_in);
      logic fb;
      fb = sig[15] ^ bit_in;
      return {sig[14:0], 1'b0} ^ (fb ? SIG_POLY : 16'h0000);
   endfunction

   // Fibonacci LFSR, x^18 + x^11 + 1 (maximal length).
   function automatic logic [17:0] lfsr_next(input logic [17:0] v);
      return {v[16:0], v[17] ^ v[10]};
   endfunction

   state_t            state_q, state_d;
   logic [17:0]       lfsr_q, lfsr_d;
   logic [N_IN-1:0]   pattern_q, pattern_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [15:0]       sig_q, sig_d;
   logic [15:0]       count_q, count_d;
   logic [17:0]       lfsr_adv_s;
   logic [15:0]       count_inc_s;

   // Next-state and datapath updates for the run sequencer.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      pattern_d   = pattern_q;
      pass_d      = pass_q;
      sig_d       = sig_q;
      count_d     = count_q;
      lfsr_adv_s  = lfsr_next(lfsr_q);
      count_inc_s = count_q + 16'd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            // Clears happen even if aborted here so pass cannot keep a stale 1.
            lfsr_d    = LOAD_VAL;
            pattern_d = LOAD_VAL[N_IN-1:0];
            sig_d     = 16'h0000;
            count_d   = 16'h0000;
            pass_d    = 1'b0;
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               sig_d   = sig_next(sig_q, resp);
               count_d = count_inc_s;
               if (count_inc_s == PAT_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_STEP;
               end
            end
         end
         S_STEP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               lfsr_d    = lfsr_adv_s;
               pattern_d = lfsr_adv_s[N_IN-1:0];
               state_d   = S_CAPTURE;
            end
         end
         S_DONE: begin
            pass_d  = (sig_q == golden);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status flags track the state being entered so they are registered.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         lfsr_q    <= 18'h00000;
         pattern_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         sig_q     <= 16'h0000;
         count_q   <= 16'h0000;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         pattern_q <= pattern_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         sig_q     <= sig_d;
         count_q   <= count_d;
      end
   end

   assign pattern   = pattern_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_q;
   assign count     = count_q;

endmodule

// File: tb/tb_cone_bist_ctrl.sv
// Self-checking bench for cone_bist_ctrl. Four instances with different
// PATTERNS/SEED share the clock and reset:
//   0: PATTERNS=1            1: PATTERNS=2, SEED=0 (replaced by 1)
//   2: PATTERNS=4            3: PATTERNS=1024 driving a stand-in cone
module tb_cone_bist_ctrl;

   logic              CK = 1'b0;
   logic              RST = 1'b1;
   logic [3:0]        start_v = 4'b0000;
   logic [3:0]        abort_v = 4'b0000;
   logic [2:0]        resp_r = 3'b000;
   logic              resp_cone;
   logic [3:0][15:0]  golden_v = '0;
   logic [3:0][17:0]  pat_v;
   logic [3:0]        busy_v, done_v, pass_v;
   logic [3:0][15:0]  sig_v, cnt_v;

   int checks = 0;
   int errors = 0;

   always #5 CK = ~CK;

   cone_bist_ctrl #(.N_IN(18), .PATTERNS(1), .SEED(18'h00001)) u_p1 (
      .CK(CK), .RST(RST), .start(start_v[0]), .abort(abort_v[0]), .golden(golden_v[0]),
      .resp(resp_r[0]), .pattern(pat_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .pass(pass_v[0]), .signature(sig_v[0]), .count(cnt_v[0]));
   cone_bist_ctrl #(.N_IN(18), .PATTERNS(2), .SEED(18'h00000)) u_p2 (
      .CK(CK), .RST(RST), .start(start_v[1]), .abort(abort_v[1]), .golden(golden_v[1]),
      .resp(resp_r[1]), .pattern(pat_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .pass(pass_v[1]), .signature(sig_v[1]), .count(cnt_v[1]));
   cone_bist_ctrl #(.N_IN(18), .PATTERNS(4), .SEED(18'h00001)) u_p4 (
      .CK(CK), .RST(RST), .start(start_v[2]), .abort(abort_v[2]), .golden(golden_v[2]),
      .resp(resp_r[2]), .pattern(pat_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .pass(pass_v[2]), .signature(sig_v[2]), .count(cnt_v[2]));
   cone_bist_ctrl #(.N_IN(18), .PATTERNS(1024), .SEED(18'h00001)) u_p1024 (
      .CK(CK), .RST(RST), .start(start_v[3]), .abort(abort_v[3]), .golden(golden_v[3]),
      .resp(resp_cone), .pattern(pat_v[3]), .busy(busy_v[3]), .done(done_v[3]),
      .pass(pass_v[3]), .signature(sig_v[3]), .count(cnt_v[3]));

   // Stand-in for the n594 cone: arbitrary combinational function of the pattern.
   function automatic logic cone_fn(input logic [17:0] p);
      return (p[0] & p[3]) ^ (p[17] | p[9]) ^ p[12];
   endfunction

   assign resp_cone = cone_fn(pat_v[3]);

   // Reference: signature after n patterns from seed 1 through the stand-in cone.
   function automatic logic [15:0] model_sig(input int n);
      logic [17:0] lfsr;
      logic [15:0] sig;
      logic        fb;
      lfsr = 18'h00001;
      sig  = 16'h0000;
      for (int i = 0; i < n; i++) begin
         fb   = sig[15] ^ cone_fn(lfsr);
         sig  = {sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         lfsr = {lfsr[16:0], lfsr[17] ^ lfsr[10]};
      end
      return sig;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   typedef struct {
      logic        start;
      logic        resp;
      logic [15:0] golden;
      logic [17:0] pat;
      logic        busy;
      logic        done;
      logic        pass;
      logic [15:0] sig;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[7];

   // Full 1024-pattern run on instance 3 with a start pulse injected mid-run.
   task automatic run_full(input string tag);
      int  busy_cycles;
      int  done_cycles;
      bit  fin;
      logic [15:0] exp_sig;
      exp_sig     = model_sig(1024);
      golden_v[3] = exp_sig;
      start_v[3]  = 1'b1;
      step();
      start_v[3]  = 1'b0;
      busy_cycles = busy_v[3] ? 1 : 0;
      done_cycles = 0;
      fin         = 1'b0;
      for (int k = 0; k < 2200 && !fin; k++) begin
         start_v[3] = (k == 100);
         step();
         if (busy_v[3]) busy_cycles++;
         if (done_v[3]) begin
            done_cycles++;
            chk({tag, "_done_count"}, 32'(cnt_v[3]), 32'd1024);
            chk({tag, "_done_sig"}, 32'(sig_v[3]), 32'(exp_sig));
         end
         if (!busy_v[3]) fin = 1'b1;
      end
      start_v[3] = 1'b0;
      chk({tag, "_done_pulses"}, 32'(done_cycles), 32'd1);
      chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd2049);
      chk({tag, "_pass"}, 32'(pass_v[3]), 32'd1);
   endtask

   initial begin
      int   done_at;
      bit   any_done;
      logic [17:0] exp_p;

      // Directed cycle table for the PATTERNS=2 instance (resp tied 1).
      //         start resp golden    pat       busy done pass sig       cnt
      tbl[0] = '{1'b1, 1'b1, 16'h3064, 18'h00000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0};
      tbl[1] = '{1'b0, 1'b1, 16'h3064, 18'h00001, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0};
      tbl[2] = '{1'b1, 1'b1, 16'h3064, 18'h00001, 1'b1, 1'b0, 1'b0, 16'h1021, 16'd1};
      tbl[3] = '{1'b0, 1'b1, 16'h3064, 18'h00002, 1'b1, 1'b0, 1'b0, 16'h1021, 16'd1};
      tbl[4] = '{1'b0, 1'b1, 16'h3064, 18'h00002, 1'b1, 1'b1, 1'b0, 16'h3063, 16'd2};
      tbl[5] = '{1'b0, 1'b1, 16'h3064, 18'h00002, 1'b0, 1'b0, 1'b0, 16'h3063, 16'd2};
      tbl[6] = '{1'b0, 1'b1, 16'h3064, 18'h00002, 1'b0, 1'b0, 1'b0, 16'h3063, 16'd2};

      resp_r = 3'b011;
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;

      // Reset state of every instance.
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
         chk($sformatf("rst_done%0d", i), 32'(done_v[i]), 32'd0);
         chk($sformatf("rst_pass%0d", i), 32'(pass_v[i]), 32'd0);
         chk($sformatf("rst_sig%0d", i), 32'(sig_v[i]), 32'd0);
         chk($sformatf("rst_cnt%0d", i), 32'(cnt_v[i]), 32'd0);
         chk($sformatf("rst_pat%0d", i), 32'(pat_v[i]), 32'd0);
      end

      // Reset in the middle of a run (instance 3 in CAPTURE).
      start_v[3] = 1'b1;
      step();
      start_v[3] = 1'b0;
      step();
      chk("midrst_pre_cnt", 32'(cnt_v[3]), 32'd0);
      chk("midrst_pre_pat", 32'(pat_v[3]), 32'd1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("midrst_busy", 32'(busy_v[3]), 32'd0);
      chk("midrst_sig", 32'(sig_v[3]), 32'd0);
      chk("midrst_cnt", 32'(cnt_v[3]), 32'd0);
      chk("midrst_pat", 32'(pat_v[3]), 32'd0);
      any_done = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (done_v[3] || busy_v[3]) any_done = 1'b1;
      end
      chk("midrst_no_activity", 32'(any_done), 32'd0);

      // Table-driven PATTERNS=2 run.
      for (int r = 0; r < 7; r++) begin
         start_v[1]  = tbl[r].start;
         resp_r[1]   = tbl[r].resp;
         golden_v[1] = tbl[r].golden;
         step();
         chk($sformatf("t%0d_pat", r), 32'(pat_v[1]), 32'(tbl[r].pat));
         chk($sformatf("t%0d_busy", r), 32'(busy_v[1]), 32'(tbl[r].busy));
         chk($sformatf("t%0d_done", r), 32'(done_v[1]), 32'(tbl[r].done));
         chk($sformatf("t%0d_pass", r), 32'(pass_v[1]), 32'(tbl[r].pass));
         chk($sformatf("t%0d_sig", r), 32'(sig_v[1]), 32'(tbl[r].sig));
         chk($sformatf("t%0d_cnt", r), 32'(cnt_v[1]), 32'(tbl[r].cnt));
      end
      start_v[1] = 1'b0;

      // Same PATTERNS=2 run with matching golden gives pass=1.
      golden_v[1] = 16'h3063;
      start_v[1]  = 1'b1;
      step();
      start_v[1]  = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("p2_match_pass", 32'(pass_v[1]), 32'd1);

      // PATTERNS=1, resp=1: done on the 3rd edge, pass one cycle later.
      golden_v[0] = 16'h1021;
      start_v[0]  = 1'b1;
      step();
      start_v[0]  = 1'b0;
      step();
      chk("p1_done_early", 32'(done_v[0]), 32'd0);
      step();
      chk("p1_done", 32'(done_v[0]), 32'd1);
      chk("p1_sig", 32'(sig_v[0]), 32'h1021);
      chk("p1_cnt", 32'(cnt_v[0]), 32'd1);
      chk("p1_pass_at_done", 32'(pass_v[0]), 32'd0);
      step();
      chk("p1_done_drop", 32'(done_v[0]), 32'd0);
      chk("p1_pass", 32'(pass_v[0]), 32'd1);
      step();
      chk("p1_pass_hold", 32'(pass_v[0]), 32'd1);

      // PATTERNS=4, resp=0: patterns 1,2,4,8, signature 0, done on edge 9.
      start_v[2] = 1'b1;
      step();
      start_v[2] = 1'b0;
      done_at = -1;
      for (int e = 2; e <= 12; e++) begin
         step();
         if (e % 2 == 0 && e <= 8) begin
            exp_p = 18'h00001 << (e / 2 - 1);
            chk($sformatf("p4_pat_e%0d", e), 32'(pat_v[2]), 32'(exp_p));
         end
         if (done_v[2] && done_at < 0) done_at = e;
      end
      chk("p4_done_edge", 32'(done_at), 32'd9);
      chk("p4_sig", 32'(sig_v[2]), 32'h0000);
      chk("p4_cnt", 32'(cnt_v[2]), 32'd4);

      // Full run on the stand-in cone, mid-run start ignored.
      run_full("full1");

      // Abort on the 5th edge of a run (CAPTURE of pattern 2).
      start_v[3] = 1'b1;
      step();
      start_v[3] = 1'b0;
      step();
      step();
      step();
      abort_v[3] = 1'b1;
      step();
      abort_v[3] = 1'b0;
      chk("abort_busy", 32'(busy_v[3]), 32'd0);
      chk("abort_cnt", 32'(cnt_v[3]), 32'd1);
      chk("abort_sig", 32'(sig_v[3]), 32'(model_sig(1)));
      chk("abort_pass", 32'(pass_v[3]), 32'd0);
      any_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (done_v[3] || busy_v[3]) any_done = 1'b1;
      end
      chk("abort_no_done", 32'(any_done), 32'd0);
      chk("abort_pass_hold", 32'(pass_v[3]), 32'd0);

      // Restart after abort reproduces the full-run signature.
      run_full("full2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
